fifo_rd_packer: RTL and testbench

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_rd_pack_pkg.sv | 19 +
 rtl/fifo_rd_packer_if.sv | 41 ++++
 rtl/fifo_rd_flush_timer.sv | 42 ++++
 rtl/fifo_rd_packer.sv | 104 ++++++++++
 tb/tb_fifo_rd_packer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pack_pkg.sv
// Shared types and default constants for the FIFO read-side word packer.
// DSIZE normally comes from defines.svh; the fallback keeps a standalone build complete.

`ifndef DSIZE
`define DSIZE 8
`endif

package fifo_rd_pack_pkg;

    localparam int unsigned PACK_DEF    = 4;
    localparam int unsigned TIMEOUT_DEF = 16;

    // FILL collects words from the FIFO, OUT presents the packed beat
    typedef enum logic [0:0] {
        StFill = 1'b0,
        StOut  = 1'b1
    } state_e;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Handshake bundle between the FIFO read port, the packer and the downstream consumer.
// master: the packer's view; slave: the environment's view.

interface fifo_rd_packer_if
    import fifo_rd_pack_pkg::*;
#(
    parameter int unsigned DSIZE = `DSIZE,
    parameter int unsigned PACK  = PACK_DEF
);

    localparam int unsigned CW = $clog2(PACK + 1);

    logic                    rempty;
    logic [DSIZE-1:0]        rdata;
    logic                    rinc;
    logic                    out_valid;
    logic                    out_ready;
    logic [DSIZE*PACK-1:0]   out_data;
    logic [CW-1:0]           out_cnt;

    modport master (
        input  rempty,
        input  rdata,
        input  out_ready,
        output rinc,
        output out_valid,
        output out_data,
        output out_cnt
    );

    modport slave (
        output rempty,
        output rdata,
        output out_ready,
        input  rinc,
        input  out_valid,
        input  out_data,
        input  out_cnt
    );

endinterface

// File: rtl/fifo_rd_flush_timer.sv
// Idle counter for partial-beat flushing (used only when FIFO_RD_PACK_FLUSH_EN is defined).
// Counts while inc_i is high, clears on clr_i, and flags the cycle it would reach TIMEOUT.

module fifo_rd_flush_timer
    import fifo_rd_pack_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // Terminal count: this increment would bring the timer to TIMEOUT
    assign expire_o = inc_i && !clr_i && (cnt_q == TW'(TIMEOUT - 1));

    // Next count: clear wins, expiry restarts, otherwise count idle cycles
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops PACK words from a FIFO read port and presents them as one wide beat.
// Optional feature: define FIFO_RD_PACK_FLUSH_EN to emit partial beats after TIMEOUT idle cycles.

module fifo_rd_packer
    import fifo_rd_pack_pkg::*;
#(
    parameter int unsigned DSIZE   = `DSIZE,
    parameter int unsigned PACK    = PACK_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              rclk,
    input  logic              rrst,
    fifo_rd_packer_if.master  bus
);

    localparam int unsigned WW = $clog2(PACK);
    localparam int unsigned CW = $clog2(PACK + 1);

    state_e                state_q, state_d;
    logic [WW-1:0]         wcnt_q, wcnt_d;
    logic [DSIZE*PACK-1:0] asm_q, asm_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pop;
    logic                  flush;

    assign pop = (state_q == StFill) && !bus.rempty && !rrst;

`ifdef FIFO_RD_PACK_FLUSH_EN
    logic timer_inc;
    logic timer_clr;

    assign timer_inc = (state_q == StFill) && (wcnt_q != '0) && bus.rempty;
    assign timer_clr = pop || (state_q != StFill) || (wcnt_q == '0);

    fifo_rd_flush_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_flush_timer (
        .clk_i    (rclk),
        .rst_i    (rrst),
        .clr_i    (timer_clr),
        .inc_i    (timer_inc),
        .expire_o (flush)
    );
`else
    assign flush = 1'b0;
`endif

    // Next-state: gather words in FILL, hold the beat in OUT until accepted
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StFill: begin
                if (pop) begin
                    asm_d[wcnt_q*DSIZE +: DSIZE] = bus.rdata;
                    if (wcnt_q == WW'(PACK - 1)) begin
                        state_d = StOut;
                        cnt_d   = CW'(PACK);
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end else if (flush) begin
                    // Unfilled slots are already zero, so the partial beat needs no masking
                    state_d = StOut;
                    cnt_d   = CW'(wcnt_q);
                    wcnt_d  = '0;
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    state_d = StFill;
                    asm_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q <= StFill;
            wcnt_q  <= '0;
            asm_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
        end
    end

    // out_data exposes the assembly register directly; it is only meaningful while out_valid
    assign bus.rinc      = pop;
    assign bus.out_valid = (state_q == StOut);
    assign bus.out_data  = asm_q;
    assign bus.out_cnt   = cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer (DSIZE=8, PACK=4, TIMEOUT=16).
// Honours FIFO_RD_PACK_FLUSH_EN in its reference model.

module tb_fifo_rd_packer;

    localparam int unsigned DSIZE   = 8;
    localparam int unsigned PACK    = 4;
    localparam int unsigned TIMEOUT = 16;

    logic clk        = 1'b0;
    logic rrst       = 1'b1;
    logic rempty_drv = 1'b1;
    logic out_ready  = 1'b0;

    always #5 clk = ~clk;

    // Word source standing in for the FIFO contents
    logic [7:0] src [0:2047];
    int         src_n    = 0;
    int         src_idx  = 0;
    bit         pop_pend = 1'b0;

    fifo_rd_packer_if #(.DSIZE(DSIZE), .PACK(PACK)) bus ();

    assign bus.rempty    = rempty_drv || (src_idx >= src_n);
    assign bus.rdata     = (src_idx < src_n) ? src[src_idx] : 8'h00;
    assign bus.out_ready = out_ready;

    fifo_rd_packer #(
        .DSIZE   (DSIZE),
        .PACK    (PACK),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .rclk (clk),
        .rrst (rrst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words collected so far and the beat on offer
    logic [7:0]  m_words [$];
    logic [7:0]  m_beat  [$];
    bit          m_valid = 1'b0;
    int          m_idle  = 0;
    bit          exp_rinc;
    logic [31:0] exp_data;

    bit          sb_en = 1'b0;
    logic [7:0]  sb_in  [$];
    logic [7:0]  sb_out [$];

    always @(posedge clk) begin
        if (pop_pend) src_idx <= src_idx + 1;
    end

    // Compare DUT against the model, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        exp_rinc = !rrst && !m_valid && !bus.rempty;
        check("rinc", 32'(bus.rinc), 32'(exp_rinc));
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) begin
            exp_data = '0;
            foreach (m_beat[i]) exp_data[i*8 +: 8] = m_beat[i];
            check("out_data", bus.out_data, exp_data);
            check("out_cnt", 32'(bus.out_cnt), 32'(m_beat.size()));
        end
        if (sb_en && !rrst && bus.out_valid && bus.out_ready) begin
            for (int i = 0; i < int'(bus.out_cnt); i++) sb_out.push_back(bus.out_data[i*8 +: 8]);
        end
        pop_pend = exp_rinc;
        if (sb_en && exp_rinc) sb_in.push_back(bus.rdata);

        if (rrst) begin
            m_words.delete();
            m_beat.delete();
            m_valid = 1'b0;
            m_idle  = 0;
        end else if (m_valid) begin
            if (bus.out_ready) begin
                m_valid = 1'b0;
                m_beat.delete();
            end
        end else if (!bus.rempty) begin
            m_words.push_back(bus.rdata);
            m_idle = 0;
            if (m_words.size() == PACK) begin
                m_beat  = m_words;
                m_words.delete();
                m_valid = 1'b1;
            end
        end
`ifdef FIFO_RD_PACK_FLUSH_EN
        else if (m_words.size() > 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_beat  = m_words;
                m_words.delete();
                m_valid = 1'b1;
                m_idle  = 0;
            end
        end
`endif
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] w);
        src[src_n] = w;
        src_n++;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (!bus.out_valid && k < budget) begin
            cyc();
            k++;
        end
        check(name, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic wait_drained(input int budget);
        int k = 0;
        while (src_idx < src_n && k < budget) begin
            cyc();
            k++;
        end
        check("src_drained", 32'(src_idx), 32'(src_n));
    endtask

    initial begin
        int k;
        bit saw;
        int exp_n;

        // Reset with words waiting: no pops while rrst is high
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        rempty_drv = 1'b0;
        cyc(2);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_cnt", 32'(bus.out_cnt), 32'd0);
        check("rst_rinc", 32'(bus.rinc), 32'd0);

        // Back-to-back fill, beat accepted immediately
        rrst      = 1'b0;
        out_ready = 1'b1;
        wait_valid("b1_valid", 10);
        check("b1_data", bus.out_data, 32'h44332211);
        check("b1_cnt", 32'(bus.out_cnt), 32'd4);
        check("b1_rinc_out", 32'(bus.rinc), 32'd0);
        cyc();
        check("b1_one_cycle", 32'(bus.out_valid), 32'd0);

        // Two consecutive beats from a continuous stream
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_valid("b2_valid", 10);
        check("b2_data", bus.out_data, 32'h04030201);
        check("b2_rinc_out", 32'(bus.rinc), 32'd0);
        cyc();
        wait_valid("b3_valid", 10);
        check("b3_data", bus.out_data, 32'h08070605);
        check("b3_rinc_out", 32'(bus.rinc), 32'd0);
        cyc();

        // Backpressure: beat held for 10 cycles while more words wait
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'hA0 + 8'(i));
        wait_valid("bp_valid", 10);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_rinc", 32'(bus.rinc), 32'd0);
            check("bp_hold_data", bus.out_data, 32'hA4A3A2A1);
        end
        out_ready = 1'b1;
        cyc();
        check("bp_accept", 32'(bus.out_valid), 32'd0);
        wait_valid("bp2_valid", 10);
        check("bp2_data", bus.out_data, 32'hA8A7A6A5);
        cyc();

        // Reset after two pops discards them
        push(8'hC1); push(8'hC2);
        wait_drained(10);
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        rrst = 1'b1;
        cyc();
        rrst = 1'b0;
        check("mr_valid", 32'(bus.out_valid), 32'd0);
        check("mr_data", bus.out_data, 32'd0);
        check("mr_cnt", 32'(bus.out_cnt), 32'd0);
        wait_valid("mr_beat_valid", 10);
        check("mr_beat_data", bus.out_data, 32'hD4D3D2D1);
        check("mr_beat_cnt", 32'(bus.out_cnt), 32'd4);
        cyc();

        // Partial beat: flushed after TIMEOUT idle cycles, or never emitted
        push(8'hAA); push(8'hBB);
        wait_drained(10);
`ifdef FIFO_RD_PACK_FLUSH_EN
        k = 0;
        while (!bus.out_valid && k < 40) begin
            cyc();
            k++;
        end
        check("flush_delay", 32'(k), 32'd16);
        check("flush_data", bus.out_data, 32'h0000BBAA);
        check("flush_cnt", 32'(bus.out_cnt), 32'd2);
        cyc();
`else
        saw = 1'b0;
        repeat (25) begin
            cyc();
            if (bus.out_valid) saw = 1'b1;
        end
        check("noflush_valid", 32'(saw), 32'd0);
        rrst = 1'b1;
        cyc();
        rrst = 1'b0;
`endif

        // Random gaps and backpressure over 1000 words, scoreboarded
        sb_en = 1'b1;
        for (int i = 0; i < 1000; i++) push(8'($urandom_range(0, 255)));
        k = 0;
        while (src_idx < src_n && k < 30000) begin
            rempty_drv = 1'($urandom_range(0, 1));
            out_ready  = 1'($urandom_range(0, 1));
            cyc();
            k++;
        end
        check("rand_drained", 32'(src_idx), 32'(src_n));
        rempty_drv = 1'b1;
        out_ready  = 1'b1;
        cyc(40);
        sb_en = 1'b0;
`ifdef FIFO_RD_PACK_FLUSH_EN
        exp_n = sb_in.size();
`else
        exp_n = sb_in.size() - (sb_in.size() % PACK);
`endif
        check("sb_count", 32'(sb_out.size()), 32'(exp_n));
        for (int i = 0; i < sb_out.size() && i < sb_in.size(); i++) begin
            check("sb_word", 32'(sb_out[i]), 32'(sb_in[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
